// File: rtl/nios_mul_result_combine_if.sv
// rtl/nios_mul_result_combine_if.sv - handshake and operand bundle between mult cell, combiner and result mux
interface nios_mul_result_combine_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] p1;
  logic [31:0] p2;
  logic [31:0] p3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport slave (
    input  in_valid, op, src_a, src_b, p1, p2, p3, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, op, src_a, src_b, p1, p2, p3, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/nios_mul_result_combine.sv
// rtl/nios_mul_result_combine.sv - combines mult-cell partial products into MUL low word or MULX high word
module nios_mul_result_combine #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int ENABLE_MULX    = 1
) (
  input  logic clk,
  input  logic reset,
  nios_mul_result_combine_if.slave bus
);

  localparam int ITER  = 16 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [31:0]      r_src_a;
  logic [31:0]      r_src_b;
  logic [16:0]      r_carry;
  logic [31:0]      r_acc;
  logic [31:0]      r_mcand;
  logic [15:0]      r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_result;
  logic             r_out_valid;

  logic        w_accept;
  logic        w_is_mulx;
  logic [32:0] w_mid;
  logic [48:0] w_low49;
  logic [31:0] w_step;
  logic [31:0] w_corr_a;
  logic [31:0] w_corr_b;
  logic [31:0] w_hi;

  assign bus.in_ready  = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign w_accept      = bus.in_valid & bus.in_ready;

  // Low-word assembly from the incoming partial products; the bits above 32 feed the hi word.
  always_comb begin
    w_mid     = {1'b0, bus.p2} + {1'b0, bus.p3};
    w_low49   = {17'b0, bus.p1} + ({16'b0, w_mid} << 16);
    w_is_mulx = (ENABLE_MULX != 0) && (bus.op != 2'b00);
  end

  // One shift-add step of a_hi*b_hi, retiring BITS_PER_CYCLE multiplier bits.
  always_comb begin
    w_step = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_mplier[k]) w_step = w_step + (r_mcand << k);
    end
  end

  // Signed correction: a negative signed operand contributes -2^32 * other operand to the product.
  always_comb begin
    w_corr_a = (r_op[1] && r_src_a[31]) ? r_src_b : 32'd0;
    w_corr_b = ((r_op == 2'b11) && r_src_b[31]) ? r_src_a : 32'd0;
    w_hi     = r_acc + {15'b0, r_carry} - w_corr_a - w_corr_b;
  end

  // Control FSM and datapath registers; accept from IDLE or HOLD takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_carry     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_op     <= bus.op;
      r_src_a  <= bus.src_a;
      r_src_b  <= bus.src_b;
      r_carry  <= w_low49[48:32];
      r_acc    <= '0;
      r_mcand  <= {16'b0, bus.src_a[31:16]};
      r_mplier <= bus.src_b[31:16];
      r_cnt    <= '0;
      if (w_is_mulx) begin
        r_state     <= S_ITER;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= S_HOLD;
        r_result    <= w_low49[31:0];
        r_out_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        S_ITER: begin
          r_acc    <= r_acc + w_step;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result    <= w_hi;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_mul_result_combine.sv
// tb/tb_nios_mul_result_combine.sv - directed self-checking bench for nios_mul_result_combine
module tb_nios_mul_result_combine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   lat;

  nios_mul_result_combine_if bus ();
  nios_mul_result_combine_if bus4 ();

  nios_mul_result_combine #(.BITS_PER_CYCLE(1), .ENABLE_MULX(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  nios_mul_result_combine #(.BITS_PER_CYCLE(4), .ENABLE_MULX(1)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q1, input logic [31:0] q2, input logic [31:0] q3);
    bus.op = op; bus.src_a = a; bus.src_b = b;
    bus.p1 = q1; bus.p2 = q2; bus.p3 = q3;
    bus.in_valid = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q1, input logic [31:0] q2, input logic [31:0] q3);
    drive(op, a, b, q1, q2, q3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 1;
    while (!bus.out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 2'b00;
    bus.src_a = '0; bus.src_b = '0; bus.p1 = '0; bus.p2 = '0; bus.p3 = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.op = 2'b00;
    bus4.src_a = '0; bus4.src_b = '0; bus4.p1 = '0; bus4.p2 = '0; bus4.p3 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // MUL low word
    issue(2'b00, 32'h00010002, 32'h00030004, 32'd8, 32'd6, 32'd4);
    wait_result(lat);
    check("mul_latency", 32'(lat), 32'd1);
    check("mul_result", bus.result, 32'h000A0008);
    @(posedge clk); #1;
    check("mul_drain_valid", 32'(bus.out_valid), 32'd0);

    // MULXUU, BITS_PER_CYCLE=1
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    check("mulxuu_busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_result(lat);
    check("mulxuu_latency", 32'(lat), 32'd18);
    check("mulxuu_result", bus.result, 32'hFFFFFFFE);

    // MULXUU, BITS_PER_CYCLE=4
    bus4.op = 2'b01; bus4.src_a = 32'hFFFFFFFF; bus4.src_b = 32'hFFFFFFFF;
    bus4.p1 = 32'hFFFE0001; bus4.p2 = 32'hFFFE0001; bus4.p3 = 32'hFFFE0001;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("mulxuu4_latency", 32'(lat), 32'd6);
    check("mulxuu4_result", bus4.result, 32'hFFFFFFFE);

    // MULXSS and MULXSU signed corrections
    @(posedge clk); #1;
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    wait_result(lat);
    check("mulxss_latency", 32'(lat), 32'd18);
    check("mulxss_result", bus.result, 32'h00000000);
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h0001FFFE, 32'h00000000, 32'h0001FFFE);
    wait_result(lat);
    check("mulxsu_result", bus.result, 32'hFFFFFFFF);
    @(posedge clk); #1;

    // backpressure: result 0x00031234 must hold while out_ready=0
    bus.out_ready = 1'b0;
    issue(2'b00, 32'h0, 32'h0, 32'h00001234, 32'h00000001, 32'h00000002);
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 32'h0, 32'h0, 32'h00005555, 32'h0, 32'h0);
      #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", bus.result, 32'h00031234);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_pulse_dropped", 32'(bus.out_valid), 32'd0);

    // reset in the middle of a MULXUU
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_result", bus.result, 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    check("midrst_abandoned", 32'(bus.out_valid), 32'd0);
    issue(2'b00, 32'h00010002, 32'h00030004, 32'd8, 32'd6, 32'd4);
    wait_result(lat);
    check("midrst_mul_latency", 32'(lat), 32'd1);
    check("midrst_mul_result", bus.result, 32'h000A0008);
    @(posedge clk); #1;

    // back-to-back MULs, then a MULX accepted out of HOLD
    drive(2'b00, 32'h00010002, 32'h00030004, 32'd8, 32'd6, 32'd4);
    @(posedge clk); #1;
    check("b2b0_valid", 32'(bus.out_valid), 32'd1);
    check("b2b0_result", bus.result, 32'h000A0008);
    drive(2'b00, 32'h0, 32'h0, 32'h00000010, 32'h00000100, 32'h00000200);
    @(posedge clk); #1;
    check("b2b1_valid", 32'(bus.out_valid), 32'd1);
    check("b2b1_result", bus.result, 32'h03000010);
    drive(2'b00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    @(posedge clk); #1;
    check("b2b2_valid", 32'(bus.out_valid), 32'd1);
    check("b2b2_result", bus.result, 32'h0000FFFF);
    drive(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("hold_mulx_valid", 32'(bus.out_valid), 32'd0);
    check("hold_mulx_in_ready", 32'(bus.in_ready), 32'd0);
    wait_result(lat);
    check("hold_mulx_latency", 32'(lat), 32'd18);
    check("hold_mulx_result", bus.result, 32'hFFFFFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/nios_mul_result_combine.md
Name: nios_mul_result_combine

Overview:
- Downstream consumer of the Nios II multiplier cell's three registered 16x16 partial products: p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo.
- Assembles the 32-bit MUL low word.
- For MULXUU/MULXSU/MULXSS, computes the 32-bit high word of the 64-bit product. The missing a_hi*b_hi term comes from an iterative shift-add, followed by a signed correction.
- Sits between the mult-cell outputs and the M/W-stage result mux, with a valid/ready handshake on both sides.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration cycle of the a_hi*b_hi shift-add. Legal values 1, 2, 4. ITER = 16/BITS_PER_CYCLE.
- ENABLE_MULX, 1: when 0, every op is treated as MUL. ITER, FIX and the hi-word logic are removed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operands/partial products valid
- in_ready  out  1  block can accept
- op  in  2  00 MUL, 01 MULXUU, 10 MULXSU (src1 signed), 11 MULXSS
- src_a  in  32  full operand A (same value that fed the cell)
- src_b  in  32  full operand B
- p1  in  32  a_lo*b_lo
- p2  in  32  a_lo*b_hi
- p3  in  32  a_hi*b_lo
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  low word (MUL) or high word (MULX*)

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset, on any cycle including mid-operation: state IDLE, out_valid=0, result=0, iteration counter and accumulators cleared. In-flight op is abandoned with no output. in_ready=1 on the first cycle after reset deasserts.
- States: IDLE, ITER, FIX, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
- Accept: in_valid & in_ready. Capture op, src_a, src_b, p1, p2, p3.
- Arithmetic, computed at accept:
  - mid = p2 + p3, 33 bits.
  - low49 = {17'b0, p1} + (mid << 16), 49 bits.
  - carry = low49[48:32], 17 bits.
  - MUL result = low49[31:0], i.e. modulo 2^32.
- MUL path: accept at cycle T → HOLD. result and out_valid=1 at T+1.
- MULX path: accept at T → ITER.
  - ITER computes p4 = src_a[31:16]*src_b[31:16], unsigned, 32 bits, by shift-add over BITS_PER_CYCLE multiplier bits per cycle.
  - Runs for exactly ITER cycles, T+1..T+ITER, counter 0..ITER-1, then → FIX.
- FIX, one cycle:
  - hi = p4 + carry, mod 2^32.
  - MULXSU: hi -= (src_a[31] ? src_b : 0).
  - MULXSS: hi -= (src_a[31] ? src_b : 0) + (src_b[31] ? src_a : 0).
  - All arithmetic mod 2^32. → HOLD; out_valid=1 at T+ITER+2 (T+18 at default).
- HOLD:
  - result and out_valid held stable while out_ready=0.
  - On out_ready=1, leave HOLD. With a simultaneous accept, go to the new op's next state; otherwise go to IDLE with out_valid=0. result may retain its last value.
- in_valid while in ITER or FIX: ignored, since in_ready=0.
- Inputs are sampled only on the accept cycle. Later input changes have no effect.
- Illegal or undriven op values are not possible, because the encoding is fully decoded.

Test Plan:
- MUL, src_a=0x00010002, src_b=0x00030004, p1=8, p2=6, p3=4 → out_valid at T+1, result=0x000A0008.
- MULXUU, src_a=src_b=0xFFFFFFFF, p1=p2=p3=0xFFFE0001 → out_valid at T+18, result=0xFFFFFFFE. Repeat with BITS_PER_CYCLE=4 → out_valid at T+6, same result.
- MULXSS, src_a=src_b=0xFFFFFFFF → result=0x00000000. MULXSU, src_a=0xFFFFFFFF, src_b=0x00000002 (p1=0x1FFFE, p2=0, p3=0x1FFFE) → result=0xFFFFFFFF.
- Backpressure: MUL result pending, out_ready=0 for 5 cycles, in_valid pulsed → result and out_valid stable, in_ready=0, pulsed op not accepted.
- Reset asserted at T+8 of a MULXUU → next cycle out_valid=0, in_ready=1, result=0. A following MUL (test 1 values) still yields 0x000A0008.
- Back-to-back: three MULs with in_valid=1 and out_ready=1 continuously → one result per cycle on consecutive cycles, each correct. A MULX accepted from HOLD starts ITER the next cycle.
